// File: rtl/sdram_pll_pkg.sv
// Shared types and helpers for the SDRAM PLL reset sequencer.
package sdram_pll_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    // Phase-counter width: enough bits to hold the largest cycle parameter.
    function automatic int phase_cnt_width(input int rst_cycles, input int stable_cycles,
                                           input int timeout_cycles, input int glitch_cycles);
        int m;
        m = rst_cycles;
        if (stable_cycles > m) m = stable_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        if (glitch_cycles > m) m = glitch_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sdram_pll_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level (PLL locked).
module sdram_pll_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/sdram_pll_reset_seq.sv
// PLL reset / lock-qualification sequencer driving the SDRAM-domain reset.
// Optional RUN-state lock-drop glitch filter: define PLL_LOCK_GLITCH_FILTER_EN.
module sdram_pll_reset_seq
    import sdram_pll_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int GLITCH_CYCLES       = 4,
    parameter int CNT_W               = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             relock_req,
    input  logic             cnt_clr,
    output logic             pll_rst,
    output logic             sdram_reset_n,
    output logic             pll_ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int PHASE_CNT_W = phase_cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                                 LOCK_TIMEOUT_CYCLES, GLITCH_CYCLES);
    localparam logic [PHASE_CNT_W-1:0] RST_LAST    = PHASE_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] STABLE_LAST = PHASE_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] TMO_LAST    = PHASE_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    pll_state_t             state_reg;
    logic [PHASE_CNT_W-1:0] cnt_reg;
    logic                   pll_rst_reg;
    logic                   sdram_reset_n_reg;
    logic                   pll_ready_reg;
    logic [CNT_W-1:0]       count_reg [2];
    logic                   locked_s;
    logic                   lost_now;
    logic                   timeout_now;
    logic                   restart;
    logic [1:0]             inc_vec;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(GLITCH_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(GLITCH_CYCLES - 1);
    logic [FILT_W-1:0] filt_reg;
`endif

    sdram_pll_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_locked_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (locked),
        .q      (locked_s)
    );

    // A relock request wins over a same-cycle timeout; a same-cycle loss is still counted.
    always_comb begin
        lost_now    = 1'b0;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        lost_now    = (state_reg == RUN) && !locked_s && (filt_reg == FILT_LAST);
`else
        lost_now    = (state_reg == RUN) && !locked_s;
`endif
        timeout_now = (state_reg == WAIT_LOCK) && !locked_s && (cnt_reg == TMO_LAST);
        restart     = (state_reg != PLL_RST) && (relock_req || lost_now || timeout_now);
        inc_vec     = {timeout_now && !relock_req, lost_now};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= PLL_RST;
            cnt_reg           <= '0;
            pll_rst_reg       <= 1'b1;
            sdram_reset_n_reg <= 1'b0;
            pll_ready_reg     <= 1'b0;
        end else if (restart) begin
            state_reg         <= PLL_RST;
            cnt_reg           <= '0;
            pll_rst_reg       <= 1'b1;
            sdram_reset_n_reg <= 1'b0;
            pll_ready_reg     <= 1'b0;
        end else begin
            case (state_reg)
                PLL_RST: begin
                    if (cnt_reg == RST_LAST) begin
                        state_reg   <= WAIT_LOCK;
                        cnt_reg     <= '0;
                        pll_rst_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + PHASE_CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // The first synced-locked cycle already counts toward stability.
                    if (locked_s) begin
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_reg         <= RUN;
                            sdram_reset_n_reg <= 1'b1;
                            pll_ready_reg     <= 1'b1;
                        end else begin
                            state_reg <= STABLE;
                            cnt_reg   <= PHASE_CNT_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + PHASE_CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_reg <= WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_reg         <= RUN;
                        sdram_reset_n_reg <= 1'b1;
                        pll_ready_reg     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + PHASE_CNT_W'(1);
                    end
                end
                RUN: begin
                end
                default: state_reg <= PLL_RST;
            endcase
        end
    end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    // Counts consecutive unlocked cycles in RUN; any locked cycle or state exit clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_reg <= '0;
        end else if ((state_reg == RUN) && !locked_s && !restart) begin
            filt_reg <= filt_reg + FILT_W'(1);
        end else begin
            filt_reg <= '0;
        end
    end
`endif

    // Index 0: loss counter, index 1: timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                count_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cnt_clr) begin
                    count_reg[i] <= CNT_W'(inc_vec[i]);
                end else if (inc_vec[i] && (count_reg[i] != {CNT_W{1'b1}})) begin
                    count_reg[i] <= count_reg[i] + CNT_W'(1);
                end
            end
        end
    end

    assign pll_rst       = pll_rst_reg;
    assign sdram_reset_n = sdram_reset_n_reg;
    assign pll_ready     = pll_ready_reg;
    assign loss_count    = count_reg[0];
    assign timeout_count = count_reg[1];

endmodule
